seq_key_lock_ctrl: RTL and testbench

- Parametrised key-management and locking wrapper for obfuscated combinational cores.
- Loads a secret key serially, checks its even parity, and commits it atomically into an active key register.
- Active key drives IN_W input XOR key gates, OUT_W registered output XOR key gates, and NUM_LUT 4:1 mux key gates (2-input LUTs).
- Sits between the chip pins/scan key port and the locked core netlist. Repeated bad loads trigger a lockout.

---
 rtl/lock_pkg.sv | 36 +++
 rtl/key_mux4_gate.sv | 19 +
 rtl/seq_key_lock_ctrl.sv | 153 +++++++++++++++
 tb/tb_seq_key_lock_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
//------------------------------------------------------------------------------
// Module : lock_pkg
// Brief  : Shared types and key-slice helpers for the key-lock wrapper.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package lock_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        CHECK   = 3'd2,
        ACTIVE  = 3'd3,
        LOCKOUT = 3'd4
    } lock_state_t;

    localparam int c_SLICE_IN  = 0;
    localparam int c_SLICE_OUT = 1;
    localparam int c_SLICE_LUT = 2;

    // XOR-reduction of key plus parity bit that marks a good load
    localparam logic c_PARITY_GOOD = 1'b0;

    // Base bit of a key slice: inputs first, then outputs, then LUT nibbles
    function automatic int key_offset(input int sel, input int in_w, input int out_w);
        case (sel)
            c_SLICE_IN:  return 0;
            c_SLICE_OUT: return in_w;
            default:     return in_w + out_w;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/key_mux4_gate.sv
//------------------------------------------------------------------------------
// Module : key_mux4_gate
// Brief  : 2-input LUT whose truth table is four key bits.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module key_mux4_gate (
    input  logic [3:0] key,
    input  logic       sel_a,
    input  logic       sel_b,
    output logic       y
);

    assign y = key[{sel_b, sel_a}];

endmodule

`default_nettype wire

// File: rtl/seq_key_lock_ctrl.sv
//------------------------------------------------------------------------------
// Module : seq_key_lock_ctrl
// Brief  : Serial key loader, parity check, commit and lockout for a locked core.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_key_lock_ctrl
    import lock_pkg::*;
#(
    parameter int IN_W     = 11,
    parameter int OUT_W    = 2,
    parameter int NUM_LUT  = 1,
    parameter int MAX_FAIL = 3,
    parameter int KEY_W    = IN_W + OUT_W + 4 * NUM_LUT,
    parameter int LUT_PW   = (NUM_LUT > 0) ? NUM_LUT : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_in,
    input  logic              key_valid,
    output logic              key_ready,
    input  logic              key_commit,
    input  logic [IN_W-1:0]   core_in_raw,
    output logic [IN_W-1:0]   core_in,
    input  logic [OUT_W-1:0]  core_out_raw,
    output logic [OUT_W-1:0]  core_out,
    input  logic [LUT_PW-1:0] lut_a,
    input  logic [LUT_PW-1:0] lut_b,
    output logic [LUT_PW-1:0] lut_y,
    output logic              unlocked,
    output logic              lockout
);

    localparam int           CNT_W      = $clog2(KEY_W + 2);
    localparam logic [CNT_W-1:0] c_CNT_FULL = CNT_W'(KEY_W + 1);
    localparam logic [3:0]   c_MAX_FAIL = 4'(MAX_FAIL);
    localparam int           c_OUT_BASE = key_offset(c_SLICE_OUT, IN_W, OUT_W);
    localparam int           c_LUT_BASE = key_offset(c_SLICE_LUT, IN_W, OUT_W);

    lock_state_t      r_state, w_state_nxt;
    logic [KEY_W:0]   r_shadow, w_shadow_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [3:0]       r_fail, w_fail_nxt, w_fail_inc;
    logic [KEY_W-1:0] r_key, w_key_nxt;
    logic             r_unlocked, w_unlocked_nxt;
    logic [OUT_W-1:0] r_core_out;
    logic             w_accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_shadow   <= '0;
            r_cnt      <= '0;
            r_fail     <= '0;
            r_key      <= '0;
            r_unlocked <= 1'b0;
            r_core_out <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_shadow   <= w_shadow_nxt;
            r_cnt      <= w_cnt_nxt;
            r_fail     <= w_fail_nxt;
            r_key      <= w_key_nxt;
            r_unlocked <= w_unlocked_nxt;
            r_core_out <= core_out_raw ^ r_key[c_OUT_BASE +: OUT_W];
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_shadow_nxt   = r_shadow;
        w_cnt_nxt      = r_cnt;
        w_fail_nxt     = r_fail;
        w_key_nxt      = r_key;
        w_unlocked_nxt = r_unlocked;
        // Counter is held at 0 in IDLE/ACTIVE, so a reload always has room
        key_ready      = (r_state == IDLE || r_state == ACTIVE || r_state == SHIFT)
                         && (r_cnt != c_CNT_FULL);
        lockout        = (r_state == LOCKOUT);
        w_accept       = key_valid && key_ready;
        w_cnt_inc      = r_cnt + CNT_W'(w_accept);
        w_fail_inc     = r_fail + 4'd1;

        case (r_state)
            IDLE, ACTIVE, SHIFT: begin
                if (w_accept) begin
                    w_shadow_nxt = {key_in, r_shadow[KEY_W:1]};
                    w_cnt_nxt    = w_cnt_inc;
                    w_state_nxt  = SHIFT;
                end
                if (key_commit) begin
                    if (w_cnt_inc == c_CNT_FULL) begin
                        w_state_nxt = CHECK;
                    end else begin
                        w_cnt_nxt  = '0;
                        w_fail_nxt = w_fail_inc;
                        if (w_fail_inc == c_MAX_FAIL) begin
                            w_state_nxt    = LOCKOUT;
                            w_key_nxt      = '0;
                            w_unlocked_nxt = 1'b0;
                        end else begin
                            w_state_nxt = r_unlocked ? ACTIVE : IDLE;
                        end
                    end
                end
            end
            CHECK: begin
                w_cnt_nxt = '0;
                if ((^r_shadow) == c_PARITY_GOOD) begin
                    w_key_nxt      = r_shadow[KEY_W-1:0];
                    w_unlocked_nxt = 1'b1;
                    w_fail_nxt     = '0;
                    w_state_nxt    = ACTIVE;
                end else begin
                    w_fail_nxt = w_fail_inc;
                    if (w_fail_inc == c_MAX_FAIL) begin
                        w_state_nxt    = LOCKOUT;
                        w_key_nxt      = '0;
                        w_unlocked_nxt = 1'b0;
                    end else begin
                        w_state_nxt = r_unlocked ? ACTIVE : IDLE;
                    end
                end
            end
            LOCKOUT: begin
                w_key_nxt      = '0;
                w_unlocked_nxt = 1'b0;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign core_in  = core_in_raw ^ r_key[IN_W-1:0];
    assign core_out = r_core_out;
    assign unlocked = r_unlocked;

    if (NUM_LUT > 0) begin : g_lut
        for (genvar i = 0; i < NUM_LUT; i++) begin : g_gate
            key_mux4_gate u_gate (
                .key   (r_key[c_LUT_BASE + 4*i +: 4]),
                .sel_a (lut_a[i]),
                .sel_b (lut_b[i]),
                .y     (lut_y[i])
            );
        end
    end else begin : g_no_lut
        assign lut_y = '0;
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_key_lock_ctrl.sv
//------------------------------------------------------------------------------
// Module : tb_seq_key_lock_ctrl
// Brief  : Directed bench with a bit-queue reference model for seq_key_lock_ctrl.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_seq_key_lock_ctrl;
    import lock_pkg::*;

    localparam int IN_W = 11, OUT_W = 2, NUM_LUT = 1, MAX_FAIL = 3;
    localparam int KEY_W = IN_W + OUT_W + 4 * NUM_LUT;
    localparam int OB = key_offset(c_SLICE_OUT, IN_W, OUT_W);
    localparam int LB = key_offset(c_SLICE_LUT, IN_W, OUT_W);

    logic clk = 1'b0, rst = 1'b1;
    logic key_in = 0, key_valid = 0, key_commit = 0, key_ready;
    logic [IN_W-1:0]    core_in_raw = '0, core_in;
    logic [OUT_W-1:0]   core_out_raw = '0, core_out;
    logic [NUM_LUT-1:0] lut_a = '0, lut_b = '0, lut_y;
    logic unlocked, lockout;

    seq_key_lock_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W), .NUM_LUT(NUM_LUT), .MAX_FAIL(MAX_FAIL)) dut (
        .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
        .key_commit(key_commit), .core_in_raw(core_in_raw), .core_in(core_in),
        .core_out_raw(core_out_raw), .core_out(core_out), .lut_a(lut_a), .lut_b(lut_b),
        .lut_y(lut_y), .unlocked(unlocked), .lockout(lockout)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0, total_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference model: received bits kept in arrival order; a commit with a
    // full load waits one cycle before the parity verdict takes effect.
    logic q_bits[$];
    bit   pending = 0, mlock = 0, munl = 0, started = 0, done = 0;
    int   fails = 0;
    logic [KEY_W-1:0] mkey = '0;
    logic [OUT_W-1:0] mco = '0;

    task automatic model_fail();
        fails++;
        if (fails == MAX_FAIL) begin
            mlock = 1; mkey = '0; munl = 0;
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            q_bits.delete(); pending = 0; mlock = 0; munl = 0; fails = 0;
            mkey = '0; mco = '0; started = 1;
        end else begin
            int ones;
            mco = core_out_raw ^ mkey[OB +: OUT_W];
            if (mlock) begin
            end else if (pending) begin
                ones = 0;
                foreach (q_bits[j]) ones += int'(q_bits[j]);
                if (ones % 2 == 0) begin
                    for (int j = 0; j < KEY_W; j++) mkey[j] = q_bits[j];
                    munl = 1; fails = 0;
                end else begin
                    model_fail();
                end
                pending = 0; q_bits.delete();
            end else begin
                if (key_valid && q_bits.size() < KEY_W + 1) q_bits.push_back(key_in);
                if (key_commit) begin
                    if (q_bits.size() == KEY_W + 1) pending = 1;
                    else begin
                        q_bits.delete(); model_fail();
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started && !done) begin
            chk("core_in",   32'(core_in),   32'(core_in_raw ^ mkey[IN_W-1:0]));
            chk("core_out",  32'(core_out),  32'(mco));
            chk("lut_y",     32'(lut_y),     32'(mkey[LB + 2*int'(lut_b[0]) + int'(lut_a[0])]));
            chk("unlocked",  32'(unlocked),  32'(munl));
            chk("lockout",   32'(lockout),   32'(mlock));
            chk("key_ready", 32'(key_ready), 32'(!mlock && !pending && q_bits.size() < KEY_W + 1));
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Shift nb bits of {parity,key}, LSB first; optionally commit with the last bit
    task automatic shift_bits(input logic [KEY_W-1:0] k, input logic p, input int nb, input bit commit_last);
        logic [KEY_W:0] v;
        v = {p, k};
        for (int j = 0; j < nb; j++) begin
            key_valid = 1; key_in = v[j];
            key_commit = (commit_last && j == nb - 1);
            tick();
        end
        key_valid = 0; key_in = 0; key_commit = 0;
    endtask

    task automatic commit();
        key_commit = 1; tick(); key_commit = 0;
    endtask

    initial begin
        repeat (3) tick();
        rst = 0;
        core_in_raw = 11'h5A3; core_out_raw = 2'b10;
        tick();
        chk("rst_core_in", 32'(core_in), 32'h5A3);
        chk("rst_core_out", 32'(core_out), 32'h2);
        chk("rst_unlocked", 32'(unlocked), 32'h0);
        chk("rst_ready", 32'(key_ready), 32'h1);
        chk("rst_lut", 32'(lut_y), 32'h0);

        // Good load 0x12345, parity bit 1 (seven ones in key)
        shift_bits(17'h12345, 1'b1, KEY_W + 1, 0);
        chk("full_ready", 32'(key_ready), 32'h0);
        commit();
        chk("chk_cycle_unl", 32'(unlocked), 32'h0);
        tick();
        chk("commit_unl", 32'(unlocked), 32'h1);
        chk("model_key", 32'(mkey), 32'h12345);
        core_in_raw = '0; core_out_raw = '0;
        tick();
        chk("key_core_in", 32'(core_in), 32'h345);
        chk("key_core_out", 32'(core_out), 32'h0);
        lut_a = 1; lut_b = 0; #1 chk("lut_a1b0", 32'(lut_y), 32'h0);
        lut_a = 0; lut_b = 0; #1 chk("lut_a0b0", 32'(lut_y), 32'h1);
        lut_a = 1; lut_b = 1; #1 chk("lut_a1b1", 32'(lut_y), 32'h1);
        tick();

        // Short commit while ACTIVE: one failure, key stays
        shift_bits(17'h00AAA, 1'b0, 10, 0);
        commit();
        tick();
        chk("short_unl", 32'(unlocked), 32'h1);
        chk("short_key", 32'(core_in), 32'h345);

        // Good load with commit on the 18th bit, then stray bits ignored
        shift_bits(17'h00AAA, 1'b0, KEY_W + 1, 1);
        tick();
        chk("last_commit_key", 32'(core_in), 32'h2AA);
        core_out_raw = 2'b11;
        shift_bits(17'h0F0F0, 1'b0, KEY_W + 4, 0);
        chk("extra_ready", 32'(key_ready), 32'h0);
        commit(); tick();
        chk("reload_key", 32'(core_in), 32'h0F0);

        // Bad parity three times; fail count was cleared by the good loads
        for (int n = 1; n <= MAX_FAIL; n++) begin
            shift_bits(17'h12345, 1'b0, KEY_W + 1, 1);
            tick();
            if (n < MAX_FAIL) chk("pre_lockout", 32'(lockout), 32'h0);
        end
        chk("lockout", 32'(lockout), 32'h1);
        chk("lock_unl", 32'(unlocked), 32'h0);
        chk("lock_core_in", 32'(core_in), 32'(core_in_raw));
        shift_bits(17'h00AAA, 1'b0, KEY_W + 1, 1);
        repeat (2) tick();
        chk("lock_sticky", 32'(lockout), 32'h1);
        chk("lock_ready", 32'(key_ready), 32'h0);

        // Reset mid-shift discards partial key and active key
        rst = 1; tick(); rst = 0;
        shift_bits(17'h12345, 1'b1, KEY_W + 1, 1);
        tick();
        chk("relock_unl", 32'(unlocked), 32'h1);
        shift_bits(17'h00AAA, 1'b0, 5, 0);
        rst = 1; tick(); rst = 0;
        chk("midrst_unl", 32'(unlocked), 32'h0);
        chk("midrst_core_in", 32'(core_in), 32'(core_in_raw));
        chk("midrst_ready", 32'(key_ready), 32'h1);
        repeat (3) tick();

        done = 1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
